pipelined_control_unit: RTL and testbench

//  RV32I main control for the 5-stage core. Decodes op in D and produces imm_src_d combinationally for the extender.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/ctrl_decode.sv | 73 +++++++
 rtl/pipelined_control_unit.sv | 100 ++++++++++
 tb/tb_pipelined_control_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, control-field encodings and per-stage control structs for the RV32I main control.
package ctrl_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       alu_src;
        logic       alu_a_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       jump;
        logic       jalr;
    } ctrl_e_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
    } ctrl_m_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decode into E-stage control bits plus the extender select.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic       valid,
    output ctrl_e_t    ctrl,
    output logic [2:0] imm_src
);
    ctrl_e_t dec;
    logic    known;

    always_comb begin
        dec     = '0;
        imm_src = IMM_I;
        known   = 1'b1;
        case (op)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                imm_src       = IMM_S;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                imm_src    = IMM_B;
                dec.alu_op = ALUOP_SUB;
                dec.branch = 1'b1;
            end
            OP_ITYPE: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALUOP_FUNCT;
            end
            OP_JAL: begin
                imm_src        = IMM_J;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
            end
            OP_LUI: begin
                imm_src        = IMM_U;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_IMM;
            end
            OP_AUIPC: begin
                imm_src       = IMM_U;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_a_src = 1'b1;
            end
            default: known = 1'b0;
        endcase
        // An invalid slot becomes a bubble; imm_src still tracks op for the extender.
        ctrl         = valid ? dec : '0;
        ctrl.valid   = valid;
        ctrl.illegal = valid & ~known;
    end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I main control with ID/EX, EX/MEM, MEM/WB control registers,
// bubble/flush/stall handling and a saturating illegal-opcode counter.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int IMM_SRC_W    = 3,
    parameter int ALU_OP_W     = 2,
    parameter int RESULT_SRC_W = 2,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              op_d,
    input  logic                    valid_d,
    input  logic                    flush_e,
    input  logic                    stall_e,
    output logic [IMM_SRC_W-1:0]    imm_src_d,
    output logic                    illegal_d,
    output logic                    valid_e,
    output logic                    valid_m,
    output logic                    valid_w,
    output logic                    reg_write_e,
    output logic                    reg_write_m,
    output logic                    reg_write_w,
    output logic                    mem_write_e,
    output logic                    mem_write_m,
    output logic [RESULT_SRC_W-1:0] result_src_e,
    output logic [RESULT_SRC_W-1:0] result_src_m,
    output logic [RESULT_SRC_W-1:0] result_src_w,
    output logic                    alu_src_e,
    output logic                    alu_a_src_e,
    output logic [ALU_OP_W-1:0]     alu_op_e,
    output logic                    branch_e,
    output logic                    jump_e,
    output logic                    jalr_e,
    output logic                    illegal_e,
    output logic [CNT_W-1:0]        illegal_count
);
    ctrl_e_t          dec, e_d, e_q;
    ctrl_m_t          m_d, m_q;
    ctrl_w_t          w_d, w_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [2:0]       imm_src;
    logic             adv;

    ctrl_decode u_decode (
        .op      (op_d),
        .valid   (valid_d),
        .ctrl    (dec),
        .imm_src (imm_src)
    );

    always_comb begin
        adv   = ~stall_e | flush_e;
        e_d   = flush_e ? '0 : stall_e ? e_q : dec;
        // A stalled E op stays put, so M must see a bubble instead of a copy.
        m_d   = '{valid:      e_q.valid & adv,
                  reg_write:  e_q.reg_write & adv,
                  mem_write:  e_q.mem_write & adv,
                  result_src: adv ? e_q.result_src : 2'b00};
        w_d   = '{valid: m_q.valid, reg_write: m_q.reg_write, result_src: m_q.result_src};
        cnt_d = (~flush_e & ~stall_e & dec.illegal & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign imm_src_d     = IMM_SRC_W'(imm_src);
    assign illegal_d     = dec.illegal;
    assign valid_e       = e_q.valid;
    assign valid_m       = m_q.valid;
    assign valid_w       = w_q.valid;
    assign reg_write_e   = e_q.reg_write;
    assign reg_write_m   = m_q.reg_write;
    assign reg_write_w   = w_q.reg_write;
    assign mem_write_e   = e_q.mem_write;
    assign mem_write_m   = m_q.mem_write;
    assign result_src_e  = RESULT_SRC_W'(e_q.result_src);
    assign result_src_m  = RESULT_SRC_W'(m_q.result_src);
    assign result_src_w  = RESULT_SRC_W'(w_q.result_src);
    assign alu_src_e     = e_q.alu_src;
    assign alu_a_src_e   = e_q.alu_a_src;
    assign alu_op_e      = ALU_OP_W'(e_q.alu_op);
    assign branch_e      = e_q.branch;
    assign jump_e        = e_q.jump;
    assign jalr_e        = e_q.jalr;
    assign illegal_e     = e_q.illegal;
    assign illegal_count = cnt_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed spec scenarios plus random traffic against a slot-based pipeline model.
module tb_pipelined_control_unit;
    logic       clk = 1'b0;
    logic       reset, valid_d, flush_e, stall_e;
    logic [6:0] op_d;
    logic [2:0] imm_src_d;
    logic       illegal_d, valid_e, valid_m, valid_w;
    logic       reg_write_e, reg_write_m, reg_write_w, mem_write_e, mem_write_m;
    logic [1:0] result_src_e, result_src_m, result_src_w, alu_op_e;
    logic       alu_src_e, alu_a_src_e, branch_e, jump_e, jalr_e, illegal_e;
    logic [1:0] illegal_count;

    int n_pass = 0;
    int n_chk  = 0;

    // Model: each stage holds the original opcode and its valid bit; fields come from the table.
    logic       e_v, m_v, w_v;
    logic [6:0] e_op, m_op, w_op;
    int         cnt;

    localparam logic [6:0] LEGAL [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                           LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b1111111;

    always #5 clk = ~clk;

    pipelined_control_unit #(.IMM_SRC_W(3), .ALU_OP_W(2), .RESULT_SRC_W(2), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .op_d(op_d), .valid_d(valid_d), .flush_e(flush_e), .stall_e(stall_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_write_e(mem_write_e), .mem_write_m(mem_write_m),
        .result_src_e(result_src_e), .result_src_m(result_src_m), .result_src_w(result_src_w),
        .alu_src_e(alu_src_e), .alu_a_src_e(alu_a_src_e), .alu_op_e(alu_op_e),
        .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e),
        .illegal_e(illegal_e), .illegal_count(illegal_count)
    );

    // rw, imm[2:0], asrc, aasrc, mw, res[1:0], aluop[1:0], br, j, jr
    function automatic logic [13:0] ref_tab(input logic [6:0] op);
        case (op)
            7'b0000011: ref_tab = 14'b1_000_1_0_0_01_00_0_0_0;
            7'b0100011: ref_tab = 14'b0_001_1_0_1_00_00_0_0_0;
            7'b0110011: ref_tab = 14'b1_000_0_0_0_00_10_0_0_0;
            7'b1100011: ref_tab = 14'b0_010_0_0_0_00_01_1_0_0;
            7'b0010011: ref_tab = 14'b1_000_1_0_0_00_10_0_0_0;
            7'b1101111: ref_tab = 14'b1_011_0_0_0_10_00_0_1_0;
            7'b1100111: ref_tab = 14'b1_000_1_0_0_10_00_0_1_1;
            7'b0110111: ref_tab = 14'b1_100_0_0_0_11_00_0_0_0;
            7'b0010111: ref_tab = 14'b1_100_1_1_0_00_00_0_0_0;
            default:    ref_tab = 14'b0;
        endcase
    endfunction

    function automatic logic legal(input logic [6:0] op);
        legal = 1'b0;
        for (int i = 0; i < 9; i++) if (LEGAL[i] == op) legal = 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        logic [13:0] te, tm, tw;
        te = e_v ? ref_tab(e_op) : 14'b0;
        tm = m_v ? ref_tab(m_op) : 14'b0;
        tw = w_v ? ref_tab(w_op) : 14'b0;
        check("valid_e", valid_e, e_v);
        check("reg_write_e", reg_write_e, te[13]);
        check("alu_src_e", alu_src_e, te[9]);
        check("alu_a_src_e", alu_a_src_e, te[8]);
        check("mem_write_e", mem_write_e, te[7]);
        check("result_src_e", result_src_e, te[6:5]);
        check("alu_op_e", alu_op_e, te[4:3]);
        check("branch_e", branch_e, te[2]);
        check("jump_e", jump_e, te[1]);
        check("jalr_e", jalr_e, te[0]);
        check("illegal_e", illegal_e, e_v && !legal(e_op));
        check("valid_m", valid_m, m_v);
        check("reg_write_m", reg_write_m, tm[13]);
        check("mem_write_m", mem_write_m, tm[7]);
        check("result_src_m", result_src_m, tm[6:5]);
        check("valid_w", valid_w, w_v);
        check("reg_write_w", reg_write_w, tw[13]);
        check("result_src_w", result_src_w, tw[6:5]);
        check("illegal_count", illegal_count, cnt);
    endtask

    // Called at a falling edge: drive, check decode, clock, advance model, check stages.
    task automatic step(input logic [6:0] op, input logic v, input logic f, input logic s, input logic r);
        logic [13:0] t;
        op_d = op; valid_d = v; flush_e = f; stall_e = s; reset = r;
        #1;
        t = ref_tab(op);
        check("imm_src_d", imm_src_d, t[12:10]);
        check("illegal_d", illegal_d, v && !legal(op));
        @(posedge clk);
        if (r) begin
            e_v = 0; m_v = 0; w_v = 0; cnt = 0;
        end else begin
            w_v = m_v; w_op = m_op;
            m_v = (s && !f) ? 1'b0 : e_v; m_op = e_op;
            if (!f && !s && v && !legal(op) && cnt < 3) cnt++;
            if (f) e_v = 0;
            else if (!s) begin e_v = v; e_op = op; end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        e_op = '0; m_op = '0; w_op = '0;
        e_v = 0; m_v = 0; w_v = 0; cnt = 0;
        op_d = '0; valid_d = 0; flush_e = 0; stall_e = 0; reset = 1;
        @(negedge clk);
        step(RT, 0, 0, 0, 1);
        step(RT, 0, 0, 0, 1);
        // R-type through the pipe
        step(RT, 1, 0, 0, 0);
        check("r_rw_e", reg_write_e, 1);
        check("r_aluop_e", alu_op_e, 2'b10);
        step(RT, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        check("r_rw_w", reg_write_w, 1);
        check("r_res_w", result_src_w, 2'b00);
        // lui then auipc
        step(LUI, 1, 0, 0, 0);
        check("lui_res_e", result_src_e, 2'b11);
        step(AUIPC, 1, 0, 0, 0);
        check("auipc_asrc_e", alu_a_src_e, 1);
        check("auipc_src_e", alu_src_e, 1);
        // load stalled one cycle
        step(LD, 1, 0, 0, 0);
        step(RT, 1, 0, 1, 0);
        check("stall_hold_res_e", result_src_e, 2'b01);
        check("stall_bubble_rw_m", reg_write_m, 0);
        step(ST, 1, 0, 0, 0);
        check("load_in_m", result_src_m, 2'b01);
        // store then flush+stall
        step(ST, 1, 0, 0, 0);
        step(RT, 0, 1, 1, 0);
        check("flush_mw_e", mem_write_e, 0);
        check("flush_valid_e", valid_e, 0);
        step(RT, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        // illegal counter: flushed one ignored, then saturation
        step(RT, 0, 0, 0, 1);
        step(BAD, 1, 1, 0, 0);
        check("flushed_bad_cnt", illegal_count, 0);
        for (int i = 0; i < 5; i++) begin
            step(BAD, 1, 0, 0, 0);
            check("bad_illegal_e", illegal_e, 1);
            check("bad_cnt_seq", illegal_count, (i < 3) ? i + 1 : 3);
        end
        // reset with work in flight
        step(LD, 1, 0, 0, 0);
        step(ST, 1, 0, 0, 0);
        step(RT, 1, 0, 0, 1);
        check("rst_valid_w", valid_w, 0);
        check("rst_cnt", illegal_count, 0);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            op = ($urandom % 4 != 0) ? LEGAL[$urandom % 9] : 7'($urandom);
            step(op, $urandom % 8 != 0, $urandom % 8 == 0, $urandom % 6 == 0, $urandom % 64 == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
